// File: rtl/async_fifo_out_stream.sv
// Read-side control of the dual-clock FIFO: synchronises the write pointer into rclk,
// owns the gray read pointer and presents popped words as a registered FWFT valid/ready stream.

module util_reset_sync (
    input  logic clk_i,
    input  logic arst_ni,
    input  logic scan_mode_i,
    output logic rst_no
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[0], 1'b1};
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= sync_d;
        end
    end

    // Scan takes the raw pin so test can control reset directly.
    assign rst_no = scan_mode_i ? arst_ni : sync_q[1];

endmodule

module util_sync #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] meta_d;
    logic [WIDTH-1:0] stable_q;
    logic [WIDTH-1:0] stable_d;

    always_comb begin
        meta_d   = d_i;
        stable_d = meta_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q   <= '0;
            stable_q <= '0;
        end else begin
            meta_q   <= meta_d;
            stable_q <= stable_d;
        end
    end

    assign q_o = stable_q;

endmodule

module async_fifo_out_stream #(
    parameter int unsigned DATA_WIDTH          = 16,
    parameter int unsigned ADDR_WIDTH          = 3,
    parameter int unsigned ALMOST_EMPTY_BUFFER = 2
) (
    input  logic                  rclk_i,
    input  logic                  aresetn_i,
    input  logic                  scan_mode_i,
    input  logic [ADDR_WIDTH:0]   wr_ptr_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic [ADDR_WIDTH:0]   rd_ptr_o,
    input  logic                  rready_i,
    output logic                  rvalid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rempty_o,
    output logic                  ralmost_empty_o,
    output logic [ADDR_WIDTH:0]   rlevel_o
);

    localparam int unsigned PW = ADDR_WIDTH + 1;

    logic          rst_n;
    logic [PW-1:0] rsync_wr_ptr;

    logic [PW-1:0]         rbin_q,   rbin_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q,  rdata_d;

    logic          rempty_c;
    logic          pop_c;
    logic [PW-1:0] rlevel_c;
    logic          ralmost_empty_c;

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = int'(PW) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    util_reset_sync u_rst_sync (
        .clk_i       (rclk_i),
        .arst_ni     (aresetn_i),
        .scan_mode_i (scan_mode_i),
        .rst_no      (rst_n)
    );

    util_sync #(
        .WIDTH (PW)
    ) u_wr_ptr_sync (
        .clk_i  (rclk_i),
        .rst_ni (rst_n),
        .d_i    (wr_ptr_i),
        .q_o    (rsync_wr_ptr)
    );

    // Status decodes straight from registers; level may legitimately reach full depth.
    always_comb begin
        rempty_c        = (rd_ptr_q == rsync_wr_ptr);
        rlevel_c        = gray2bin(rsync_wr_ptr) - rbin_q;
        ralmost_empty_c = (32'(rlevel_c) <= ALMOST_EMPTY_BUFFER);
        pop_c           = ~rempty_c & (~rvalid_q | rready_i);
    end

    always_comb begin
        rbin_d   = rbin_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        if (pop_c) begin
            rbin_d   = rbin_q + PW'(1);
            rvalid_d = 1'b1;
            rdata_d  = rdata_i;
        end else if (rready_i) begin
            rvalid_d = 1'b0;
        end
        rd_ptr_d = rbin_d ^ (rbin_d >> 1);
    end

    always_ff @(posedge rclk_i or negedge rst_n) begin
        if (!rst_n) begin
            rbin_q   <= '0;
            rd_ptr_q <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rbin_q   <= rbin_d;
            rd_ptr_q <= rd_ptr_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign rd_ptr_o        = rd_ptr_q;
    assign rvalid_o        = rvalid_q;
    assign rdata_o         = rdata_q;
    assign rempty_o        = rempty_c;
    assign ralmost_empty_o = ralmost_empty_c;
    assign rlevel_o        = rlevel_c;

endmodule
